manchester_frame_sink: RTL and testbench
========================================

Name: manchester_frame_sink

Overview:
- Sits directly downstream of the Manchester decoder.
- Consumes its decoded_byte/byte_valid stream, groups bytes into fixed-length frames of FRAME_SIZE bytes, checks a trailing CRC-8, and buffers good frames in a store-and-forward byte FIFO.
- Drains frames as AXI-Stream with tlast on the final payload byte.
- Bad, overflowed or timed-out frames are discarded and counted.

Parameters:
- FRAME_SIZE, 4, bytes per frame delivered by the decoder, including the CRC byte when checking is enabled; minimum 2.
- DEPTH, 64, FIFO depth in bytes; power of two, at least FRAME_SIZE.
- TIMEOUT, 1024, idle cycles after which a partially received frame is abandoned.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- decoded_byte  in  8  byte from the decoder.
- byte_valid  in  1  single-cycle qualifier for decoded_byte.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last payload byte of a frame.
- frames_ok  out  16  count of committed frames, saturating.
- crc_err_count  out  16  count of frames dropped for CRC mismatch, saturating.
- drop_count  out  16  count of frames dropped for overflow or timeout, saturating.

Behaviour:
- Reset: all pointers, byte counter, CRC register, timeout counter, flags and status counters go to 0; m_axis_tvalid=0, m_axis_tlast=0. A reset mid-frame discards the partial frame and any uncommitted bytes.
- Storage: DEPTH entries of 9 bits, {last, byte}. Three pointers, each log2(DEPTH)+1 bits wide: wr_ptr, commit_ptr, rd_ptr.
- FIFO full when wr_ptr - rd_ptr == DEPTH.
- Payload bytes are byte indices 0..FRAME_SIZE-2. Each payload byte with byte_valid=1 is written at wr_ptr on that clock edge, and wr_ptr increments.
  - last=1 only for index FRAME_SIZE-2.
  - The CRC register updates with the byte in the same edge.
- CRC: CRC-8, polynomial 0x07, init 0x00, MSB first, no reflection, no final XOR. Computed over the payload bytes only.
- Byte index FRAME_SIZE-1 is the CRC byte. It is not stored. On its byte_valid edge:
  - If the overflow flag is set: wr_ptr <= commit_ptr, drop_count++.
  - Else if the CRC does not match: wr_ptr <= commit_ptr, crc_err_count++.
  - Else: commit_ptr <= wr_ptr, frames_ok++.
  - In all three cases: byte index <= 0, CRC <= 0, overflow flag cleared.
- Overflow: if a payload byte arrives while the FIFO is full, it is not written and the overflow flag is set. The remaining bytes of that frame are still counted, but not written.
- Timeout: the idle counter runs while byte index != 0, and resets on every byte_valid.
  - On reaching TIMEOUT-1: wr_ptr <= commit_ptr, byte index <= 0, CRC <= 0, flag cleared, drop_count++.
  - byte_valid in the same cycle wins; no timeout fires.
- Output side:
  - m_axis_tvalid = (rd_ptr != commit_ptr). tdata/tlast are read combinationally from the entry at rd_ptr.
  - rd_ptr increments on tvalid && tready.
  - Uncommitted bytes are never visible on the output.
- Latency: the committing CRC byte arrives in cycle N; tvalid is high in cycle N+1 if the FIFO was previously empty.
- tvalid, once high, stays high with stable tdata/tlast until the handshake.
- Simultaneous write and read in one cycle are both honoured. Full is evaluated on pre-edge pointers, so a read in the same cycle does not free space for that cycle's write.
- Pointer arithmetic is modulo 2*DEPTH and wraps naturally.
- Status counters saturate at 0xFFFF.

Optional Feature:
- Macro: MANCHESTER_FRAME_CRC_EN.
- Defined: behaviour as above.
- Undefined:
  - No CRC logic is built.
  - All FRAME_SIZE bytes are payload and stored; last=1 on index FRAME_SIZE-1.
  - The frame commits on that byte's edge unless overflow is flagged.
  - crc_err_count is tied to 0.

Test Plan:
- Bytes 0x01,0x02,0x03,0x48, spaced 16 cycles apart, tready=1 -> output 0x01,0x02,0x03 with tlast on 0x03; tvalid first high the cycle after 0x48; frames_ok=1.
- Same frame with CRC byte 0x49 -> no output; crc_err_count=1; wr_ptr returns to commit_ptr.
- tready=0, DEPTH=4, send two good frames -> first frame committed; second flagged as overflow and dropped, drop_count=1. Then tready=1 -> exactly 3 bytes out, with tlast on the third.
- Send 0x01,0x02, then 1024 idle cycles, then a good frame 0x01,0x02,0x03,0x48 -> drop_count=1, then a clean output of the good frame.
- Assert aresetn=0 for one cycle after 2 payload bytes, then send a good frame -> only the good frame appears; all counters read 0 except frames_ok=1.
- Without MANCHESTER_FRAME_CRC_EN: send 0xAA,0xBB,0xCC,0xDD -> 4 bytes out, tlast on 0xDD, frames_ok=1.

Source files
------------

// File: rtl/manchester_frame_sink.sv
`default_nettype none
// ============================================================================
// Module  : manchester_frame_sink
// Purpose : Frames decoder bytes and optionally checks a CRC-8
//           (MANCHESTER_FRAME_CRC_EN). Good frames are buffered store-and-forward
//           and drained as AXI-Stream.
// Revision: 1.0
// ============================================================================
module manchester_frame_sink #(
    parameter int FRAME_SIZE = 4,
    parameter int DEPTH      = 64,
    parameter int TIMEOUT    = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  decoded_byte,
    input  logic        byte_valid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frames_ok,
    output logic [15:0] crc_err_count,
    output logic [15:0] drop_count
);

    localparam int               c_aw       = $clog2(DEPTH);
    localparam int               c_iw       = $clog2(FRAME_SIZE);
    localparam int               c_tw       = $clog2(TIMEOUT) + 1;
    localparam logic [c_aw:0]    c_depth    = (c_aw + 1)'(DEPTH);
    localparam logic [c_iw-1:0]  c_last_idx = c_iw'(FRAME_SIZE - 1);
    localparam logic [c_tw-1:0]  c_tmo      = c_tw'(TIMEOUT - 1);
`ifdef MANCHESTER_FRAME_CRC_EN
    localparam logic [c_iw-1:0]  c_last_pay = c_iw'(FRAME_SIZE - 2);
`else
    localparam logic [c_iw-1:0]  c_last_pay = c_last_idx;
`endif

    logic [8:0]      r_mem [DEPTH];
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_commit_ptr;
    logic [c_aw:0]   r_rd_ptr;
    logic [c_iw-1:0] r_idx;
    logic            r_ovf;
    logic [c_tw-1:0] r_idle;
    logic [15:0]     r_frames_ok;
    logic [15:0]     r_drop;

    logic [c_aw:0]   w_used;
    logic            w_full;
    logic            w_end;
    logic            w_pay;
    logic            w_write;
    logic            w_ovf_now;
    logic            w_timeout;
    logic            w_rd;
    logic [8:0]      w_head;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef MANCHESTER_FRAME_CRC_EN
    logic [7:0]  r_crc;
    logic [15:0] r_crc_err;
    logic [7:0]  w_crc_next;

    // CRC-8, poly 0x07, MSB first
    function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign w_crc_next    = crc8(r_crc, decoded_byte);
    assign w_pay         = byte_valid && (r_idx != c_last_idx);
    assign crc_err_count = r_crc_err;
`else
    assign w_pay         = byte_valid;
    assign crc_err_count = 16'd0;
`endif

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == c_depth);
    assign w_end     = byte_valid && (r_idx == c_last_idx);
    assign w_write   = w_pay && !w_full;
    assign w_ovf_now = r_ovf || (w_pay && w_full);
    assign w_timeout = !byte_valid && (r_idx != '0) && (r_idle == c_tmo);
    assign w_rd      = m_axis_tvalid && m_axis_tready;

    assign w_head        = r_mem[r_rd_ptr[c_aw-1:0]];
    assign m_axis_tvalid = (r_rd_ptr != r_commit_ptr);
    assign m_axis_tdata  = w_head[7:0];
    // Gate tlast with tvalid so never-written entries cannot leak out
    assign m_axis_tlast  = m_axis_tvalid && w_head[8];
    assign frames_ok     = r_frames_ok;
    assign drop_count    = r_drop;

    always_ff @(posedge aclk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= {(r_idx == c_last_pay), decoded_byte};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_idx        <= '0;
            r_ovf        <= 1'b0;
            r_idle       <= '0;
            r_frames_ok  <= 16'd0;
            r_drop       <= 16'd0;
`ifdef MANCHESTER_FRAME_CRC_EN
            r_crc        <= 8'd0;
            r_crc_err    <= 16'd0;
`endif
        end else begin
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (byte_valid || w_timeout || (r_idx == '0)) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end

            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_end) begin
                r_idx <= '0;
                r_ovf <= 1'b0;
`ifdef MANCHESTER_FRAME_CRC_EN
                r_crc <= 8'd0;
`endif
                if (w_ovf_now) begin
                    r_wr_ptr <= r_commit_ptr;
                    r_drop   <= sat_inc(r_drop);
`ifdef MANCHESTER_FRAME_CRC_EN
                end else if (r_crc != decoded_byte) begin
                    r_wr_ptr  <= r_commit_ptr;
                    r_crc_err <= sat_inc(r_crc_err);
`endif
                end else begin
                    r_commit_ptr <= w_write ? r_wr_ptr + 1'b1 : r_wr_ptr;
                    r_frames_ok  <= sat_inc(r_frames_ok);
                end
            end else if (byte_valid) begin
                r_idx <= r_idx + 1'b1;
                if (w_pay && w_full) begin
                    r_ovf <= 1'b1;
                end
`ifdef MANCHESTER_FRAME_CRC_EN
                r_crc <= w_crc_next;
`endif
            end else if (w_timeout) begin
                r_wr_ptr <= r_commit_ptr;
                r_idx    <= '0;
                r_ovf    <= 1'b0;
                r_drop   <= sat_inc(r_drop);
`ifdef MANCHESTER_FRAME_CRC_EN
                r_crc    <= 8'd0;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_manchester_frame_sink.sv
`default_nettype none
// ============================================================================
// Module  : tb_manchester_frame_sink
// Purpose : Directed self-checking bench for manchester_frame_sink (DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_manchester_frame_sink;

`ifdef MANCHESTER_FRAME_CRC_EN
    localparam int NPAY = 3;
`else
    localparam int NPAY = 4;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  decoded_byte;
    logic        byte_valid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] frames_ok;
    logic [15:0] crc_err_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int stab_viol = 0;
    int exp_ok = 0;
    int exp_drop = 0;
    int exp_crc = 0;

    logic [7:0] good_frame [4];
    logic [7:0] rx_d [$];
    logic       rx_l [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    manchester_frame_sink #(
        .FRAME_SIZE (4),
        .DEPTH      (4),
        .TIMEOUT    (1024)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .decoded_byte  (decoded_byte),
        .byte_valid    (byte_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frames_ok     (frames_ok),
        .crc_err_count (crc_err_count),
        .drop_count    (drop_count)
    );

    always #5 aclk = ~aclk;

    // Output monitor: records handshakes and checks hold-while-stalled
    always @(negedge aclk) begin
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
            stab_viol++;
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            rx_d.push_back(m_axis_tdata);
            rx_l.push_back(m_axis_tlast);
        end
        prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
        prev_d     = m_axis_tdata;
        prev_l     = m_axis_tlast;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        decoded_byte = b;
        byte_valid   = 1'b1;
        tick(1);
        byte_valid   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f [4], input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(f[i]);
            if (i < 3 && gap > 1) tick(gap - 1);
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (frames_ok !== 16'd0) begin errors++; $display("FAIL reset_frames_ok: got %0d expected 0", frames_ok); end
        checks++; if (crc_err_count !== 16'd0) begin errors++; $display("FAIL reset_crc_err: got %0d expected 0", crc_err_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    endtask

    task automatic test_basic;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        for (int i = 0; i < 3; i++) begin
            send_byte(good_frame[i]);
            tick(15);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_uncommitted_hidden: tvalid got %b expected 0", m_axis_tvalid); end
        send_byte(good_frame[3]);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency: tvalid got %b expected 1", m_axis_tvalid); end
        tick(NPAY + 3);
        exp_ok++;
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL basic_count: got %0d bytes expected %0d", rx_d.size(), NPAY); end
        for (int i = 0; i < NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i] || rx_l[i] !== (i == NPAY - 1)) begin
                    errors++; $display("FAIL basic_byte%0d: got %h/%b expected %h/%b", i, rx_d[i], rx_l[i], good_frame[i], (i == NPAY - 1));
                end
            end
        end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL basic_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
    endtask

`ifdef MANCHESTER_FRAME_CRC_EN
    task automatic test_crc_err;
        logic [7:0] bad [4];
        bad[0] = 8'h01; bad[1] = 8'h02; bad[2] = 8'h03; bad[3] = 8'h49;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        send_frame(bad, 16);
        tick(6);
        exp_crc++;
        checks++; if (rx_d.size() !== 0) begin errors++; $display("FAIL crc_no_output: got %0d bytes expected 0", rx_d.size()); end
        checks++; if (crc_err_count !== 16'(exp_crc)) begin errors++; $display("FAIL crc_err_count: got %0d expected %0d", crc_err_count, exp_crc); end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL crc_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
        send_frame(good_frame, 2);
        tick(6);
        exp_ok++;
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL crc_rewind: got %0d bytes expected %0d", rx_d.size(), NPAY); end
        for (int i = 0; i < NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i]) begin errors++; $display("FAIL crc_rewind_byte%0d: got %h expected %h", i, rx_d[i], good_frame[i]); end
            end
        end
    endtask
`endif

    task automatic test_overflow;
        m_axis_tready = 1'b0;
        rx_d.delete(); rx_l.delete();
        send_frame(good_frame, 1);
        send_frame(good_frame, 1);
        tick(5);
        exp_ok++; exp_drop++;
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== good_frame[0]) begin
            errors++; $display("FAIL ovf_head: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, good_frame[0]);
        end
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL ovf_drop: got %0d expected %0d", drop_count, exp_drop); end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL ovf_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
        m_axis_tready = 1'b1;
        tick(10);
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL ovf_count: got %0d bytes expected %0d", rx_d.size(), NPAY); end
        for (int i = 0; i < NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i] || rx_l[i] !== (i == NPAY - 1)) begin
                    errors++; $display("FAIL ovf_byte%0d: got %h/%b expected %h/%b", i, rx_d[i], rx_l[i], good_frame[i], (i == NPAY - 1));
                end
            end
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drained: tvalid got %b expected 0", m_axis_tvalid); end
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL ovf_stable: got %0d violations expected 0", stab_viol); end
    endtask

    task automatic test_timeout;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        send_byte(good_frame[0]);
        send_byte(good_frame[1]);
        tick(1100);
        exp_drop++;
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL tmo_drop: got %0d expected %0d", drop_count, exp_drop); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tmo_no_output: tvalid got %b expected 0", m_axis_tvalid); end
        send_frame(good_frame, 2);
        tick(6);
        exp_ok++;
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL tmo_count: got %0d bytes expected %0d", rx_d.size(), NPAY); end
        for (int i = 0; i < NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i] || rx_l[i] !== (i == NPAY - 1)) begin
                    errors++; $display("FAIL tmo_byte%0d: got %h/%b expected %h/%b", i, rx_d[i], rx_l[i], good_frame[i], (i == NPAY - 1));
                end
            end
        end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL tmo_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
    endtask

    task automatic test_no_early_timeout;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        send_byte(good_frame[0]);
        tick(1015);
        send_byte(good_frame[1]);
        send_byte(good_frame[2]);
        send_byte(good_frame[3]);
        tick(6);
        exp_ok++;
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL slow_drop: got %0d expected %0d", drop_count, exp_drop); end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL slow_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL slow_count: got %0d bytes expected %0d", rx_d.size(), NPAY); end
    endtask

    task automatic test_back_to_back;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        send_frame(good_frame, 2);
        tick(1);
        send_frame(good_frame, 2);
        tick(8);
        exp_ok += 2;
        checks++; if (rx_d.size() !== 2 * NPAY) begin errors++; $display("FAIL b2b_count: got %0d bytes expected %0d", rx_d.size(), 2 * NPAY); end
        for (int i = 0; i < 2 * NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i % NPAY] || rx_l[i] !== ((i % NPAY) == NPAY - 1)) begin
                    errors++; $display("FAIL b2b_byte%0d: got %h/%b expected %h/%b", i, rx_d[i], rx_l[i], good_frame[i % NPAY], ((i % NPAY) == NPAY - 1));
                end
            end
        end
        checks++; if (frames_ok !== 16'(exp_ok)) begin errors++; $display("FAIL b2b_frames_ok: got %0d expected %0d", frames_ok, exp_ok); end
        checks++; if (drop_count !== 16'(exp_drop)) begin errors++; $display("FAIL b2b_drop: got %0d expected %0d", drop_count, exp_drop); end
    endtask

    task automatic test_reset_mid_frame;
        m_axis_tready = 1'b1;
        rx_d.delete(); rx_l.delete();
        send_byte(good_frame[0]);
        send_byte(good_frame[1]);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        exp_ok = 0; exp_drop = 0; exp_crc = 0;
        send_frame(good_frame, 2);
        tick(6);
        exp_ok++;
        checks++; if (rx_d.size() !== NPAY) begin errors++; $display("FAIL rst_count: got %0d bytes expected %0d", rx_d.size(), NPAY); end
        for (int i = 0; i < NPAY; i++) begin
            if (rx_d.size() > i) begin
                checks++; if (rx_d[i] !== good_frame[i] || rx_l[i] !== (i == NPAY - 1)) begin
                    errors++; $display("FAIL rst_byte%0d: got %h/%b expected %h/%b", i, rx_d[i], rx_l[i], good_frame[i], (i == NPAY - 1));
                end
            end
        end
        checks++; if (frames_ok !== 16'd1) begin errors++; $display("FAIL rst_frames_ok: got %0d expected 1", frames_ok); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_count); end
        checks++; if (crc_err_count !== 16'd0) begin errors++; $display("FAIL rst_crc_err: got %0d expected 0", crc_err_count); end
    endtask

    initial begin
`ifdef MANCHESTER_FRAME_CRC_EN
        good_frame[0] = 8'h01; good_frame[1] = 8'h02; good_frame[2] = 8'h03; good_frame[3] = 8'h48;
`else
        good_frame[0] = 8'hAA; good_frame[1] = 8'hBB; good_frame[2] = 8'hCC; good_frame[3] = 8'hDD;
`endif
        aresetn       = 1'b0;
        byte_valid    = 1'b0;
        decoded_byte  = 8'h00;
        m_axis_tready = 1'b0;
        tick(1);
        test_reset;
        test_basic;
`ifdef MANCHESTER_FRAME_CRC_EN
        test_crc_err;
`endif
        test_overflow;
        test_timeout;
        test_no_early_timeout;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
